// File: rtl/port_arb.sv
// Round-robin output-port arbiter: grants one requesting input port at a time,
// rejects requesters while the output is not ready, and force-releases a stuck grant.
module port_arb #(
  parameter int PORTNUM = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [PORTNUM-1:0]         i_req,
  input  logic                       i_ready,
  input  logic                       i_done,
  output logic [PORTNUM-1:0]         o_resp,
  output logic [PORTNUM-1:0]         o_nresp,
  output logic                       o_busy,
  output logic [$clog2(PORTNUM)-1:0] o_grant_port,
  output logic                       o_grant_vld,
  output logic                       o_timeout
);

  localparam int PW = $clog2(PORTNUM);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [PW-1:0] PTR_INIT = PW'(PORTNUM - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [PW-1:0]        last_r, last_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic [PORTNUM-1:0]   resp_r, resp_nxt_s;
  logic [PORTNUM-1:0]   nresp_r, nresp_nxt_s;
  logic [PW-1:0]        port_r, port_nxt_s;
  logic                 busy_r, vld_r, vld_nxt_s, tmo_r, tmo_nxt_s;
  logic [PW-1:0]        win_s, idx_s;

  // Round-robin winner search: descending loop so the nearest bit after last_r wins
  always_comb begin
    win_s = '0;
    idx_s = '0;
    for (int i = PORTNUM; i >= 1; i--) begin
      idx_s = PW'((int'(last_r) + i) % PORTNUM);
      win_s = i_req[idx_s] ? idx_s : win_s;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    cnt_nxt_s   = cnt_r;
    resp_nxt_s  = '0;
    nresp_nxt_s = '0;
    port_nxt_s  = port_r;
    vld_nxt_s   = 1'b0;
    tmo_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req != '0) begin
          if (i_ready) begin
            state_nxt_s        = ST_BUSY;
            last_nxt_s         = win_s;
            port_nxt_s         = win_s;
            resp_nxt_s[win_s]  = 1'b1;
            vld_nxt_s          = 1'b1;
            cnt_nxt_s          = '0;
          end else begin
            nresp_nxt_s = i_req;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // i_done outranks a coincident timeout
        if (i_done) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          tmo_nxt_s   = 1'b1;
        end else begin
          cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
      last_r  <= PTR_INIT;
      cnt_r   <= '0;
      resp_r  <= '0;
      nresp_r <= '0;
      port_r  <= '0;
      busy_r  <= 1'b0;
      vld_r   <= 1'b0;
      tmo_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      cnt_r   <= cnt_nxt_s;
      resp_r  <= resp_nxt_s;
      nresp_r <= nresp_nxt_s;
      port_r  <= port_nxt_s;
      busy_r  <= (state_nxt_s == ST_BUSY);
      vld_r   <= vld_nxt_s;
      tmo_r   <= tmo_nxt_s;
    end
  end

  assign o_resp       = resp_r;
  assign o_nresp      = nresp_r;
  assign o_busy       = busy_r;
  assign o_grant_port = port_r;
  assign o_grant_vld  = vld_r;
  assign o_timeout    = tmo_r;

endmodule
